// File: rtl/amo_seq_ctrl_if.sv
// Data-memory port between the AMO sequencer (master) and the LSU arbiter (slave).
interface amo_seq_ctrl_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [1:0]        mem_wlen;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wlen,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wlen,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/amo_seq_ctrl.sv
// RV64A AMO/LR/SC sequencer: read/modify/write on the data port, LR reservation, rd value.
// Optional OIRV_AMO_MISALIGN_CHK_EN: misaligned addresses complete at once with misaligned=1.
module amo_seq_ctrl #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [4:0]        funct5,
  input  logic              is_word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   src,
  input  logic              flush,
  input  logic              trap,
  amo_seq_ctrl_if.master    mem,
  output logic              hold,
  output logic              done,
  output logic [XLEN-1:0]   rd_data,
  output logic              misaligned
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MOD, S_WR, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SWAP = 5'b00001,
    OP_LR   = 5'b00010,
    OP_SC   = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_OR   = 5'b01000,
    OP_AND  = 5'b01100,
    OP_MIN  = 5'b10000,
    OP_MAX  = 5'b10100,
    OP_MINU = 5'b11000,
    OP_MAXU = 5'b11100
  } amo_op_e;

  state_e            state_q, state_d;
  logic [4:0]        op_q;
  logic              word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   src_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   ld_q;
  logic              resv_valid_q;
  logic [ADDR_W-1:0] resv_addr_q;

  logic              accept;
  logic              sc_hit;
  logic              start_mis;
  logic [XLEN-1:0]   op_a_s, op_b_s, op_a_u, op_b_u, alu_res;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {{(XLEN-32){1'b0}}, v};
  endfunction

  assign accept = (state_q == S_IDLE) && start && !flush;
  assign sc_hit = resv_valid_q && (resv_addr_q == addr);

`ifdef OIRV_AMO_MISALIGN_CHK_EN
  logic mis_q;
  always_comb begin
    start_mis = is_word ? (addr[1:0] != 2'b00) : (addr[2:0] != 3'b000);
  end
`else
  always_comb begin
    start_mis = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (start_mis)            state_d = S_DONE;
          else if (funct5 == OP_SC) state_d = sc_hit ? S_WR : S_DONE;
          else                      state_d = S_RD;
        end
      end
      S_RD:    if (mem.mem_ack) state_d = (op_q == OP_LR) ? S_DONE : S_MOD;
      S_MOD:   state_d = S_WR;
      S_WR:    if (mem.mem_ack) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // .W operands: sign- or zero-extend the low words so one 64-bit ALU serves both widths
  always_comb begin
    op_a_s = word_q ? sext32(ld_q[31:0])  : ld_q;
    op_b_s = word_q ? sext32(src_q[31:0]) : src_q;
    op_a_u = word_q ? zext32(ld_q[31:0])  : ld_q;
    op_b_u = word_q ? zext32(src_q[31:0]) : src_q;
    case (op_q)
      OP_SWAP: alu_res = op_b_s;
      OP_XOR:  alu_res = op_a_s ^ op_b_s;
      OP_OR:   alu_res = op_a_s | op_b_s;
      OP_AND:  alu_res = op_a_s & op_b_s;
      OP_MIN:  alu_res = ($signed(op_a_s) < $signed(op_b_s)) ? op_a_s : op_b_s;
      OP_MAX:  alu_res = ($signed(op_a_s) < $signed(op_b_s)) ? op_b_s : op_a_s;
      OP_MINU: alu_res = (op_a_u < op_b_u) ? op_a_u : op_b_u;
      OP_MAXU: alu_res = (op_a_u < op_b_u) ? op_b_u : op_a_u;
      default: alu_res = op_a_s + op_b_s;
    endcase
  end

  // ld_q doubles as the rd result: SC status is preloaded at accept, loads overwrite it
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q    <= '0;
      word_q  <= 1'b0;
      addr_q  <= '0;
      src_q   <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
`ifdef OIRV_AMO_MISALIGN_CHK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= funct5;
            word_q  <= is_word;
            addr_q  <= addr;
            src_q   <= src;
            wdata_q <= src;
            ld_q    <= (funct5 == OP_SC && !sc_hit && !start_mis) ?
                       {{(XLEN-1){1'b0}}, 1'b1} : '0;
`ifdef OIRV_AMO_MISALIGN_CHK_EN
            mis_q   <= start_mis;
`endif
          end
        end
        S_RD:    if (mem.mem_ack) ld_q <= word_q ? sext32(mem.mem_rdata[31:0]) : mem.mem_rdata;
        S_MOD:   wdata_q <= alu_res;
        default: ;
      endcase
    end
  end

  // Clearing wins over an LR completing in the same cycle as a trap or flush
  always_ff @(posedge clk) begin
    if (!rstn) begin
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else if (trap || flush || (accept && funct5 == OP_SC)) begin
      resv_valid_q <= 1'b0;
    end else if (state_q == S_RD && mem.mem_ack && op_q == OP_LR) begin
      resv_valid_q <= 1'b1;
      resv_addr_q  <= addr_q;
    end
  end

  always_comb begin
    hold          = accept || (state_q != S_IDLE && state_q != S_DONE);
    mem.mem_req   = (state_q == S_RD) || (state_q == S_WR);
    mem.mem_we    = (state_q == S_WR);
    mem.mem_addr  = addr_q;
    mem.mem_wdata = wdata_q;
    mem.mem_wlen  = ((state_q == S_RD) || (state_q == S_WR)) ?
                    (word_q ? 2'd2 : 2'd3) : 2'd0;
    done          = (state_q == S_DONE);
    rd_data       = ld_q;
`ifdef OIRV_AMO_MISALIGN_CHK_EN
    misaligned    = (state_q == S_DONE) && mis_q;
`else
    misaligned    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_amo_seq_ctrl.sv
// Randomized bench for amo_seq_ctrl against an operation-level reference model.
module tb_amo_seq_ctrl;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  funct5 = '0;
  logic        is_word = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] src = '0;
  logic        flush = 1'b0;
  logic        trap = 1'b0;
  logic        hold, done, misaligned;
  logic [63:0] rd_data;

  amo_seq_ctrl_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mif ();

  amo_seq_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .funct5(funct5), .is_word(is_word),
    .addr(addr), .src(src), .flush(flush), .trap(trap), .mem(mif.master),
    .hold(hold), .done(done), .rd_data(rd_data), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] dut_mem [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];
  bit          rv = 1'b0;
  logic [63:0] ra = '0;
  int unsigned rd_delay = 0, wr_delay = 0;
  int unsigned rd_cnt = 0, wr_cnt = 0, req_cyc = 0, wait_cnt = 0;
  logic [63:0] last_wdata = '0, exp_addr = '0, tx_addr = '0, tx_wdata = '0;
  logic [1:0]  exp_wlen = '0;
  bit          in_txn = 1'b0, tx_we = 1'b0;
  logic [63:0] pool [4] = '{64'h100, 64'h108, 64'h200, 64'h300};
  logic [4:0]  ops [12] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h08,
                            5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h05};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] amo_ref(input logic [4:0] f, input logic w,
                                          input logic [63:0] m, input logic [63:0] s);
    int a32, b32;
    int unsigned au32, bu32;
    longint a64, b64;
    longint unsigned au64, bu64;
    a32 = m[31:0]; b32 = s[31:0]; au32 = m[31:0]; bu32 = s[31:0];
    a64 = m; b64 = s; au64 = m; bu64 = s;
    if (w) begin
      case (f)
        5'h01:   return {32'h0, b32};
        5'h04:   return {32'h0, a32 ^ b32};
        5'h08:   return {32'h0, a32 | b32};
        5'h0C:   return {32'h0, a32 & b32};
        5'h10:   return {32'h0, (a32 < b32) ? a32 : b32};
        5'h14:   return {32'h0, (a32 > b32) ? a32 : b32};
        5'h18:   return {32'h0, (au32 < bu32) ? au32 : bu32};
        5'h1C:   return {32'h0, (au32 > bu32) ? au32 : bu32};
        default: return {32'h0, a32 + b32};
      endcase
    end
    case (f)
      5'h01:   return b64;
      5'h04:   return a64 ^ b64;
      5'h08:   return a64 | b64;
      5'h0C:   return a64 & b64;
      5'h10:   return (a64 < b64) ? a64 : b64;
      5'h14:   return (a64 > b64) ? a64 : b64;
      5'h18:   return (au64 < bu64) ? au64 : bu64;
      5'h1C:   return (au64 > bu64) ? au64 : bu64;
      default: return a64 + b64;
    endcase
  endfunction

  // Memory slave: programmable ack delay, serves/updates its own copy of memory
  always @(negedge clk) begin
    if (!rstn) begin
      mif.mem_ack = 1'b0;
      mif.mem_rdata = '0;
      in_txn = 1'b0;
    end else if (mif.mem_req) begin
      req_cyc++;
      if (!in_txn) begin
        in_txn = 1'b1; wait_cnt = 0;
        tx_addr = mif.mem_addr; tx_we = mif.mem_we; tx_wdata = mif.mem_wdata;
        check("mem_addr", mif.mem_addr, exp_addr);
        check("mem_wlen", 64'(mif.mem_wlen), 64'(exp_wlen));
      end else begin
        check("addr_stable", mif.mem_addr, tx_addr);
        check("we_stable", 64'(mif.mem_we), 64'(tx_we));
        if (tx_we) check("wdata_stable", mif.mem_wdata, tx_wdata);
      end
      if (!dut_mem.exists(tx_addr)) dut_mem[tx_addr] = '0;
      if (wait_cnt >= (tx_we ? wr_delay : rd_delay)) begin
        mif.mem_ack = 1'b1; in_txn = 1'b0;
        if (tx_we) begin
          wr_cnt++; last_wdata = mif.mem_wdata;
          if (mif.mem_wlen == 2'd2) dut_mem[tx_addr] = {dut_mem[tx_addr][63:32], mif.mem_wdata[31:0]};
          else                      dut_mem[tx_addr] = mif.mem_wdata;
        end else begin
          rd_cnt++;
          if (mif.mem_wlen == 2'd2) mif.mem_rdata = {$urandom(), dut_mem[tx_addr][31:0]};
          else                      mif.mem_rdata = dut_mem[tx_addr];
        end
      end else begin
        mif.mem_ack = 1'b0; wait_cnt++;
      end
    end else begin
      mif.mem_ack = 1'b0; in_txn = 1'b0;
    end
  end

  task automatic mem_set(input logic [63:0] a, input logic [63:0] v);
    dut_mem[a] = v; ref_mem[a] = v;
  endtask

  task automatic do_op(input logic [4:0] f5, input logic w, input logic [63:0] a,
                       input logic [63:0] s, input int unsigned rdd, input int unsigned wrd,
                       input bit fl_mid);
    bit is_lr, is_sc, mis, seen, fl;
    int unsigned exp_lat, exp_rds, exp_wrs, r0, w0, q0, cyc;
    logic [63:0] old, v, exp_rd, exp_wd;
    is_lr = (f5 == 5'h02); is_sc = (f5 == 5'h03); mis = 1'b0;
`ifdef OIRV_AMO_MISALIGN_CHK_EN
    mis = w ? (a[1:0] != 2'b00) : (a[2:0] != 3'b000);
`endif
    exp_rds = 0; exp_wrs = 0; exp_wd = '0; exp_rd = '0; exp_lat = 1;
    fl = fl_mid && !is_lr && !is_sc && !mis;
    if (!ref_mem.exists(a)) ref_mem[a] = '0;
    old = ref_mem[a];
    if (mis) begin
      if (is_sc) rv = 1'b0;
    end else if (is_sc) begin
      if (rv && ra == a) begin
        exp_lat = 2 + wrd; exp_wrs = 1;
        exp_wd = w ? {32'h0, s[31:0]} : s;
        ref_mem[a] = w ? {old[63:32], s[31:0]} : s;
      end else begin
        exp_rd = 64'd1;
      end
      rv = 1'b0;
    end else begin
      exp_rds = 1;
      exp_rd = w ? {{32{old[31]}}, old[31:0]} : old;
      if (is_lr) begin
        exp_lat = 2 + rdd; rv = 1'b1; ra = a;
      end else begin
        v = amo_ref(f5, w, old, s);
        exp_lat = 4 + rdd + wrd; exp_wrs = 1;
        exp_wd = w ? {32'h0, v[31:0]} : v;
        ref_mem[a] = w ? {old[63:32], v[31:0]} : v;
        if (fl) rv = 1'b0;
      end
    end

    @(negedge clk);
    rd_delay = rdd; wr_delay = wrd; exp_addr = a; exp_wlen = w ? 2'd2 : 2'd3;
    funct5 = f5; is_word = w; addr = a; src = s; start = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt; q0 = req_cyc;
    #1 check("hold_accept", 64'(hold), 64'd1);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 64) begin
      @(negedge clk);
      cyc++; start = 1'b0;
      flush = fl && (cyc == 2);
      if (done) seen = 1'b1;
      else      check("hold_busy", 64'(hold), 64'd1);
    end
    flush = 1'b0;
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    else begin
      check("latency", 64'(cyc), 64'(exp_lat));
      check("rd_data", rd_data, exp_rd);
      check("misaligned", 64'(misaligned), 64'(mis));
      check("hold_done", 64'(hold), 64'd0);
    end
    check("reads", 64'(rd_cnt - r0), 64'(exp_rds));
    check("writes", 64'(wr_cnt - w0), 64'(exp_wrs));
    check("req_cycles", 64'(req_cyc - q0), 64'(exp_rds * (rdd + 1) + exp_wrs * (wrd + 1)));
    if (exp_wrs != 0) check("wdata", w ? {32'h0, last_wdata[31:0]} : last_wdata, exp_wd);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic trap_pulse();
    @(negedge clk); trap = 1'b1;
    @(negedge clk); trap = 1'b0;
    rv = 1'b0;
  endtask

  task automatic flushed_start(input logic [63:0] a);
    int unsigned q0;
    @(negedge clk);
    q0 = req_cyc; funct5 = 5'h02; is_word = 1'b0; addr = a; start = 1'b1; flush = 1'b1;
    #1 check("hold_flushed", 64'(hold), 64'd0);
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check("flushed_done", 64'(done), 64'd0);
    @(negedge clk);
    check("flushed_req", 64'(req_cyc - q0), 64'd0);
    rv = 1'b0;
  endtask

  initial begin
    logic [4:0]  f5;
    logic [63:0] a;
    bit          w;
    for (int i = 0; i < 4; i++) mem_set(pool[i], {$urandom(), $urandom()});

    repeat (3) @(negedge clk);
    check("rst_req", 64'(mif.mem_req), 64'd0);
    check("rst_we", 64'(mif.mem_we), 64'd0);
    check("rst_addr", mif.mem_addr, 64'd0);
    check("rst_wdata", mif.mem_wdata, 64'd0);
    check("rst_wlen", 64'(mif.mem_wlen), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rd", rd_data, 64'd0);
    check("rst_mis", 64'(misaligned), 64'd0);
    check("rst_hold", 64'(hold), 64'd0);
    rstn = 1'b1;

    // AMOADD.D, zero-wait
    mem_set(64'h100, 64'd5);
    do_op(5'h00, 1'b0, 64'h100, 64'd7, 0, 0, 1'b0);
    check("add_wr12", last_wdata, 64'd12);

    // signed vs unsigned word minimum
    mem_set(64'h108, 64'hFFFF_FFFF);
    do_op(5'h10, 1'b1, 64'h108, 64'd1, 0, 0, 1'b0);
    check("minw_wr", {32'h0, last_wdata[31:0]}, 64'hFFFF_FFFF);
    mem_set(64'h108, 64'hFFFF_FFFF);
    do_op(5'h18, 1'b1, 64'h108, 64'd1, 0, 0, 1'b0);
    check("minuw_wr", {32'h0, last_wdata[31:0]}, 64'h1);

    // LR/SC pair, then a repeated SC fails
    do_op(5'h02, 1'b0, 64'h200, 64'd0, 0, 0, 1'b0);
    do_op(5'h03, 1'b0, 64'h200, 64'd9, 0, 0, 1'b0);
    check("sc_wr9", last_wdata, 64'd9);
    do_op(5'h03, 1'b0, 64'h200, 64'd9, 0, 0, 1'b0);

    // trap and flushed start both kill the reservation
    do_op(5'h02, 1'b1, 64'h300, 64'd0, 1, 0, 1'b0);
    trap_pulse();
    do_op(5'h03, 1'b1, 64'h300, 64'd3, 0, 0, 1'b0);
    do_op(5'h02, 1'b0, 64'h200, 64'd0, 0, 0, 1'b0);
    flushed_start(64'h200);
    do_op(5'h03, 1'b0, 64'h200, 64'd4, 0, 0, 1'b0);

    // slow memory with a flush mid-operation
    do_op(5'h04, 1'b0, 64'h108, 64'hA5A5_0000_FFFF_1234, 3, 3, 1'b1);

`ifdef OIRV_AMO_MISALIGN_CHK_EN
    do_op(5'h01, 1'b0, 64'h104, 64'd1, 0, 0, 1'b0);
    do_op(5'h02, 1'b0, 64'h100, 64'd0, 0, 0, 1'b0);
    do_op(5'h03, 1'b0, 64'h101, 64'd1, 0, 0, 1'b0);
    do_op(5'h03, 1'b0, 64'h100, 64'd1, 0, 0, 1'b0);
`endif

    for (int i = 0; i < 200; i++) begin
      f5 = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0) f5 = 5'h03;
      a = pool[$urandom_range(0, 3)];
      w = 1'($urandom_range(0, 1));
      if (f5 == 5'h03 && rv && $urandom_range(0, 2) != 0) a = ra;
`ifdef OIRV_AMO_MISALIGN_CHK_EN
      if ($urandom_range(0, 9) == 0) a = a + 64'($urandom_range(1, 7));
`endif
      do_op(f5, w, a, {$urandom(), $urandom()}, $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 3) == 0);
      case ($urandom_range(0, 19))
        0:       trap_pulse();
        1:       flushed_start(pool[$urandom_range(0, 3)]);
        default: ;
      endcase
    end

    for (int i = 0; i < 4; i++) check("mem_final", dut_mem[pool[i]], ref_mem[pool[i]]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/amo_seq_ctrl.md
Name: amo_seq_ctrl

Overview:
- Sequencer for RV64A atomics once they have been latched into the EX2 stage.
- Owns the data-memory port for the duration of an AMO/LR/SC and holds the pipeline registers meanwhile.
- Runs each operation as a read / modify / write sequence, keeps the LR reservation, and produces the rd writeback value.
- Sits between the EX/EX2 pipeline register and the LSU memory port arbiter.

Parameters:
- XLEN, 64, data width of rs2, rd and memory data.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- start  in  1  EX2 holds a valid, uncancelled AMO/LR/SC.
- funct5  in  5  instr[31:27].
- is_word  in  1  1 = .W (32-bit), 0 = .D.
- addr  in  ADDR_W  effective address (reg_data0).
- src  in  XLEN  rs2 data (reg_data1).
- flush  in  1  pipeline flush.
- trap  in  1  trap/mret taken; clears the reservation.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  XLEN  write data.
- mem_wlen  out  2  0 = byte, 2 = word, 3 = dword.
- mem_ack  in  1  request accepted/complete.
- mem_rdata  in  XLEN  read data, valid with mem_ack on reads.
- hold  out  1  stall to EX/EX2 and earlier stages.
- done  out  1  one-cycle completion pulse.
- rd_data  out  XLEN  rd writeback value, valid with done.
- misaligned  out  1  misalignment indication (optional feature only).

Behaviour:
- Reset: rstn is synchronous, active-low, on clk. Outputs reset to mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wlen=0, done=0, rd_data=0, misaligned=0. Internal state: FSM=IDLE, resv_valid=0, resv_addr=0.
- hold = (state!=IDLE && state!=DONE) || (state==IDLE && start && !flush). Combinational.
- funct5 encodings: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100. Unlisted codes are treated as ADD.
- FSM states: IDLE, RD, MOD, WR, DONE.
- IDLE: on start && !flush, capture funct5/is_word/addr/src.
  - SC with resv_valid && resv_addr==addr -> WR.
  - SC otherwise -> DONE with rd_data=1 and no memory access.
  - All others -> RD.
  - Any SC clears resv_valid in this cycle.
- RD: mem_req=1, mem_we=0, mem_addr/mem_wlen stable until the mem_ack cycle.
  - On ack, capture the loaded value: .W is sign-extended from bit 31.
  - LR: set resv_valid=1, resv_addr=addr, go to DONE.
  - Otherwise go to MOD.
- MOD (1 cycle): compute new = f(loaded, src).
  - .W: operate on bits [31:0] only. MIN/MAX are signed, MINU/MAXU unsigned, all at the operand width. Writes the low 32 bits.
  - Go to WR.
- WR: mem_req=1, mem_we=1, mem_wdata=new (SC: src). Hold until mem_ack, then DONE.
- DONE (1 cycle): done=1, hold=0.
  - rd_data = loaded (AMO/LR), 0 (SC success) or 1 (SC fail).
  - Next state is IDLE; a new start is not accepted in this cycle.
- mem_req deasserts the cycle after ack.
- Latency with zero-wait memory (ack in the first req cycle):
  - AMO: 4 cycles start->done.
  - LR: 2 cycles.
  - SC success: 2 cycles.
  - SC fail: 1 cycle.
- flush: sampled only in IDLE and suppresses start. Once an operation has left IDLE it completes atomically; flush has no effect on it.
- trap or flush in any state clears resv_valid. An SC in flight already passed its check.
- Reservation granule is exact address equality. An LR overwrites any existing reservation.
- start && flush in the same cycle: no operation; resv_valid is cleared.

Optional Feature:
- Macro: OIRV_AMO_MISALIGN_CHK_EN.
- Defined: in IDLE, an address not aligned to the access size (.W: addr[1:0]!=0; .D: addr[2:0]!=0) goes directly to DONE.
  - No memory access, misaligned=1 with done, rd_data=0.
  - The reservation is unchanged, except that an SC still clears it.
- Undefined: misaligned is tied to 0 and addresses are issued unmodified.

Test Plan:
- AMOADD.D: addr=0x100, mem=5, src=7, zero-wait ack -> read 0x100, then write 12, done at cycle 4, rd_data=5, hold high for cycles 0-3.
- AMOMIN.W vs AMOMINU.W: mem word 0xFFFFFFFF, src=1.
  - MIN writes 0xFFFFFFFF, rd_data=0xFFFFFFFFFFFFFFFF.
  - MINU writes 0x00000001.
- LR.D 0x200 then SC.D 0x200 src=9 -> SC writes 9, rd_data=0.
  - A second SC.D 0x200 -> no mem_req, rd_data=1.
- LR.W 0x300, then trap pulse, then SC.W 0x300 -> SC fails, rd_data=1, no write.
- Mem ack delayed 3 cycles in RD and in WR -> mem_addr/mem_wdata stable throughout, hold high.
  - A flush asserted mid-operation is ignored; the write still occurs.
- With OIRV_AMO_MISALIGN_CHK_EN: AMOSWAP.D addr=0x104 -> misaligned=1 with done after 1 cycle, mem_req never asserted.
